apb_master: RTL and testbench
=============================

# apb_master

APB4 requester that converts a simple valid/ready command stream into single APB transfers on PCLK and returns one response per command. It sits directly upstream of the APB `Slave` block and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT. It samples PRDATA/PREADY/PSLVERR from the slave. A wait-state timeout guarantees forward progress when a slave never asserts PREADY.

## Interface
- ADDR_SIZE, 32, APB address width
- DATA_SIZE, 32, APB data width; multiple of 8
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables timeout
- PCLK  in  1  APB clock; all logic rising-edge
- PRESET  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_SIZE  transfer address
- cmd_wdata  in  DATA_SIZE  write data
- cmd_strb  in  DATA_SIZE/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and aborts
- rsp_slverr  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  ADDR_SIZE, PPROT  out  3, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  DATA_SIZE, PSTRB  out  DATA_SIZE/8  APB request
- PRDATA  in  DATA_SIZE, PREADY  in  1, PSLVERR  in  1  APB completer response

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - cmd_ready = 1 (combinational from state).
  - On cmd_valid, latch cmd_* into the APB output registers and go to SETUP.
  - For reads, PSTRB is forced to 0.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Unconditionally go to ACCESS.
  - PREADY is ignored in this state.
- **ACCESS**
  - PSEL = 1, PENABLE = 1.
  - A wait counter increments every cycle in ACCESS.
  - On PREADY = 1: capture PRDATA (reads only; writes capture 0) and PSLVERR, set rsp_timeout = 0, go to RESP.
  - If the counter reaches TIMEOUT without PREADY (TIMEOUT ≠ 0): rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
- **RESP**
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_* hold until rsp_ready, then go to IDLE.
- Stability rules:
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT are constant from SETUP through the last ACCESS cycle.
  - These outputs hold their last values in RESP and IDLE.
- Back-to-back commands:
  - cmd_ready is 0 outside IDLE, so at most one transfer is outstanding.
  - Minimum spacing is 4 cycles per transfer: IDLE, SETUP, ACCESS, RESP.
- Reset:
  - While PRESET is asserted, state = IDLE and the wait counter = 0.
  - All outputs are 0, except cmd_ready, which is 1 only after reset deasserts.
  - Asserting PRESET mid-transfer drops PSEL/PENABLE immediately and discards the response; no rsp_valid follows.

## Timing
- All APB outputs and rsp_* are registered; cmd_ready is combinational from state only.
- Command accepted at edge E:
  - PSEL rises after E.
  - PENABLE rises after E+1.
  - With zero wait states, PREADY is sampled at E+2 and rsp_valid rises after E+2.
- Each wait state adds 1 cycle.
- The timeout fires at the edge ending the TIMEOUT-th ACCESS cycle. PSEL falls and rsp_valid rises after that edge.
- If PREADY = 1 occurs in the same cycle that the counter reaches TIMEOUT, PREADY wins: normal completion, rsp_timeout = 0.
- Counter width is $clog2(TIMEOUT+1). The counter saturates at TIMEOUT and clears on entry to SETUP.

## Structure
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - PPROT_W = 3
  - function strb_width(DATA_SIZE) = DATA_SIZE/8
- One natural sub-module: apb_wait_timer. It contains the clear, count and saturate logic and outputs an expired flag. It is instantiated only when TIMEOUT ≠ 0.

## Test plan
- Zero-wait write:
  - Stimulus: cmd addr 0x123, wdata 0xDEADBEEF, strb 4'b1011; responder PREADY = 1 in ACCESS.
  - Required: PSEL at E+1, PENABLE at E+2, PSTRB = 4'b1011; rsp_valid at E+3 with rdata 0, slverr 0.
- Read with 3 wait states:
  - Stimulus: PRDATA = 0xCAFEF00D at PREADY.
  - Required: PSTRB = 0 throughout, PADDR stable; rsp_valid at E+6 with rsp_rdata 0xCAFEF00D.
- Error response:
  - Stimulus: PREADY = 1, PSLVERR = 1 on a write.
  - Required: rsp_slverr = 1, rsp_timeout = 0.
- Timeout:
  - Stimulus: TIMEOUT = 16, PREADY held 0.
  - Required: exactly 16 ACCESS cycles, then PSEL = 0; rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles, cmd_valid held high.
  - Required: rsp_valid and rsp_* stable, cmd_ready = 0, PSEL = 0; the next transfer's PSEL rises 2 cycles after the rsp handshake.
- Reset mid-ACCESS:
  - Stimulus: assert PRESET asynchronously during ACCESS.
  - Required: PSEL/PENABLE = 0 before the next PCLK edge; after release, cmd_ready = 1 and no rsp_valid is produced.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester: FSM state encoding, protection width, strobe width.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int PPROT_W = 3;

    function automatic int strb_width(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB4 request/completer signals for one requester.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
) ();

    localparam int STRB_W = strb_width(DATA_SIZE);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_SIZE-1:0]  cmd_addr;
    logic [DATA_SIZE-1:0]  cmd_wdata;
    logic [STRB_W-1:0]     cmd_strb;
    logic [PPROT_W-1:0]    cmd_prot;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_SIZE-1:0]  rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;

    logic [ADDR_SIZE-1:0]  PADDR;
    logic [PPROT_W-1:0]    PPROT;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_SIZE-1:0]  PWDATA;
    logic [STRB_W-1:0]     PSTRB;
    logic [DATA_SIZE-1:0]  PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared on SETUP entry, counts ACCESS cycles, saturates at TIMEOUT.
// expired_o is combinational and flags the edge that ends the TIMEOUT-th counted cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of ACCESS cycles already completed
    assign expired_o = inc_i && (cnt_q >= LAST);

endmodule

// File: rtl/apb_master.sv
// APB4 requester: one command in, one SETUP/ACCESS transfer, one response out; cmd_ready only in IDLE.
// Zero-wait latency: PSEL after accept edge, rsp_valid two edges later; rsp_* held until rsp_ready.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    localparam int STRB_W = strb_width(DATA_SIZE);

    apb_state_e            state_q,       state_d;
    logic [ADDR_SIZE-1:0]  paddr_q,       paddr_d;
    logic [PPROT_W-1:0]    pprot_q,       pprot_d;
    logic                  pwrite_q,      pwrite_d;
    logic [DATA_SIZE-1:0]  pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]     pstrb_q,       pstrb_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_SIZE-1:0]  rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_slverr_q,  rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic timer_clr;
    logic timer_inc;
    logic timer_expired;

    generate
        if (TIMEOUT != 0) begin : g_timer
            apb_wait_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_wait_timer (
                .clk_i     (PCLK),
                .rst_i     (PRESET),
                .clr_i     (timer_clr),
                .inc_i     (timer_inc),
                .expired_o (timer_expired)
            );
        end else begin : g_no_timer
            assign timer_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clr     = 1'b0;
        timer_inc     = (state_q == ACCESS);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = SETUP;
                    paddr_d   = bus.cmd_addr;
                    pprot_d   = bus.cmd_prot;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_wdata;
                    pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
                    timer_clr = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout landing on the same edge
                if (bus.PREADY) begin
                    state_d       = RESP;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_slverr_d  = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Gated by PRESET so cmd_ready stays low for the whole reset window
    assign bus.cmd_ready   = (state_q == IDLE) && !PRESET;

    assign bus.PADDR       = paddr_q;
    assign bus.PPROT       = pprot_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scripted commands, a programmable APB completer and a response scoreboard.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int SW         = DW / 8;
    localparam int TB_TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    apb_master #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          timeout;
    } rsp_t;

    rsp_t exp_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;

    int            cfg_ws   = 0;
    bit            cfg_hang = 1'b0;
    logic [DW-1:0] cfg_rd   = '0;
    bit            cfg_err  = 1'b0;
    int            acc_idx  = 0;
    int            acc_total = 0;
    int            lat_k    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Completer: answers after cfg_ws wait states, or never when cfg_hang.
    // Drives junk with PREADY=1 during SETUP, which the requester must ignore.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) begin
                if (!cfg_hang && acc_idx == cfg_ws) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = cfg_rd;
                    bus.PSLVERR = cfg_err;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 32'h5A5A_0000 | acc_idx;
                    bus.PSLVERR = 1'b1;
                end
                acc_idx++;
                acc_total = acc_idx;
            end else if (bus.PSEL) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = 32'hBAD0_BAD0;
                bus.PSLVERR = 1'b1;
                acc_idx     = 0;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = '0;
                bus.PSLVERR = 1'b0;
                acc_idx     = 0;
            end
        end
    end

    // Monitor: request stability across SETUP/ACCESS, and response scoreboard on handshake.
    initial begin
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic [SW-1:0] c_strb;
        logic [2:0]    c_prot;
        logic          c_write;
        rsp_t          e;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && !bus.PENABLE) begin
                c_addr  = bus.PADDR;
                c_wdata = bus.PWDATA;
                c_strb  = bus.PSTRB;
                c_prot  = bus.PPROT;
                c_write = bus.PWRITE;
            end else if (bus.PSEL && bus.PENABLE) begin
                chk("paddr_stable",  bus.PADDR,  c_addr);
                chk("pwdata_stable", bus.PWDATA, c_wdata);
                chk("pstrb_stable",  bus.PSTRB,  c_strb);
                chk("pprot_stable",  bus.PPROT,  c_prot);
                chk("pwrite_stable", bus.PWRITE, c_write);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata",   bus.rsp_rdata,   e.rdata);
                    chk("rsp_slverr",  bus.rsp_slverr,  e.slverr);
                    chk("rsp_timeout", bus.rsp_timeout, e.timeout);
                end
            end
        end
    end

    task automatic push_exp(input logic wr, input bit hang, input logic [DW-1:0] rd, input bit err);
        rsp_t e;
        e.rdata   = (hang || wr) ? '0 : rd;
        e.slverr  = hang ? 1'b1 : err;
        e.timeout = hang;
        exp_q.push_back(e);
    endtask

    // Presents one command, passes the accept edge and the SETUP->ACCESS edge.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [2:0] prot, input int ws,
                         input bit hang, input logic [DW-1:0] rd, input bit err,
                         input bit push, input bit keep);
        int n;
        cfg_ws   = ws;
        cfg_hang = hang;
        cfg_rd   = rd;
        cfg_err  = err;
        if (push) push_exp(wr, hang, rd, err);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_prot  = prot;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk("cmd_ready", bus.cmd_ready, 1);
        @(posedge PCLK); #1;
        if (!keep) bus.cmd_valid = 1'b0;
        chk("psel_setup",    bus.PSEL,    1);
        chk("penable_setup", bus.PENABLE, 0);
        chk("paddr",         bus.PADDR,   addr);
        chk("pstrb",         bus.PSTRB,   wr ? strb : '0);
        chk("pwrite",        bus.PWRITE,  wr);
        chk("pprot",         bus.PPROT,   prot);
        if (wr) chk("pwdata", bus.PWDATA, wdata);
        @(posedge PCLK); #1;
        chk("psel_access",    bus.PSEL,    1);
        chk("penable_access", bus.PENABLE, 1);
        lat_k = 1;
    endtask

    // Waits for rsp_valid, checks latency, holds rsp_ready low for delay cycles, then handshakes.
    task automatic complete(input int exp_lat, input int delay);
        logic [DW-1:0] s_rd;
        logic          s_err;
        logic          s_to;
        while (!bus.rsp_valid && lat_k < 200) begin
            @(posedge PCLK); #1;
            lat_k++;
        end
        chk("rsp_latency",  lat_k,       exp_lat);
        chk("psel_resp",    bus.PSEL,    0);
        chk("penable_resp", bus.PENABLE, 0);
        s_rd  = bus.rsp_rdata;
        s_err = bus.rsp_slverr;
        s_to  = bus.rsp_timeout;
        for (int i = 0; i < delay; i++) begin
            @(posedge PCLK); #1;
            chk("bp_rsp_valid", bus.rsp_valid,   1);
            chk("bp_rdata",     bus.rsp_rdata,   s_rd);
            chk("bp_slverr",    bus.rsp_slverr,  s_err);
            chk("bp_timeout",   bus.rsp_timeout, s_to);
            chk("bp_cmd_ready", bus.cmd_ready,   0);
            chk("bp_psel",      bus.PSEL,        0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 0);
    endtask

    initial begin
        int seen;
        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready,  0);
        chk("rst_psel",      bus.PSEL,       0);
        chk("rst_penable",   bus.PENABLE,    0);
        chk("rst_rsp_valid", bus.rsp_valid,  0);
        chk("rst_paddr",     bus.PADDR,      0);
        chk("rst_pstrb",     bus.PSTRB,      0);
        chk("rst_rdata",     bus.rsp_rdata,  0);
        chk("rst_slverr",    bus.rsp_slverr, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        @(posedge PCLK); #1;

        // zero-wait write, read with 3 waits, write error, read error
        issue(1, 32'h123, 32'hDEADBEEF, 4'b1011, 3'b010, 0, 0, 32'h1357_9BDF, 0, 1, 0);
        complete(2, 0);
        issue(0, 32'h400, 32'h1111_2222, 4'hF, 3'b001, 3, 0, 32'hCAFEF00D, 0, 1, 0);
        complete(5, 0);
        issue(1, 32'h808, 32'h0BAD_F00D, 4'b0110, 3'b100, 1, 0, 32'hDEAD_0003, 1, 1, 0);
        complete(3, 1);
        issue(0, 32'hFFFF_FFFC, 32'h0, 4'hF, 3'b111, 2, 0, 32'h1234_5678, 1, 1, 0);
        complete(4, 0);

        // timeout, then PREADY arriving on the last allowed ACCESS cycle
        issue(0, 32'h55AA, 32'h0, 4'hF, 3'b000, 0, 1, 32'hFEED, 0, 1, 0);
        complete(TB_TIMEOUT + 1, 0);
        chk("timeout_access_cycles", acc_total, TB_TIMEOUT);
        issue(0, 32'h6000, 32'h0, 4'hF, 3'b011, TB_TIMEOUT - 1, 0, 32'hA5A5_5A5A, 0, 1, 0);
        complete(TB_TIMEOUT + 1, 0);
        chk("limit_access_cycles", acc_total, TB_TIMEOUT);

        // response backpressure with cmd_valid held, then back-to-back spacing
        issue(1, 32'h7000, 32'h0102_0304, 4'b1100, 3'b010, 0, 0, 32'h0, 0, 1, 1);
        complete(2, 5);
        chk("b2b_idle_psel",      bus.PSEL,      0);
        chk("b2b_idle_cmd_ready", bus.cmd_ready, 1);
        push_exp(1, 0, 32'h0, 0);
        @(posedge PCLK); #1;
        bus.cmd_valid = 1'b0;
        chk("b2b_psel",    bus.PSEL,    1);
        chk("b2b_penable", bus.PENABLE, 0);
        @(posedge PCLK); #1;
        chk("b2b_penable_access", bus.PENABLE, 1);
        lat_k = 1;
        complete(2, 0);

        // asynchronous reset during ACCESS: no response may follow
        issue(0, 32'h9000, 32'h0, 4'hF, 3'b000, 0, 1, 32'h0, 0, 0, 0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        chk("arst_psel",      bus.PSEL,      0);
        chk("arst_penable",   bus.PENABLE,   0);
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        bus.rsp_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge PCLK); #1;
            if (bus.rsp_valid) seen++;
        end
        bus.rsp_ready = 1'b0;
        chk("arst_no_rsp", seen, 0);

        // recovery transfer after reset
        issue(0, 32'hA000, 32'h0, 4'hF, 3'b001, 0, 0, 32'h0F0F_F0F0, 0, 1, 0);
        complete(2, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
